// File: rtl/alu_packet_engine.sv
// Command-side packet engine of the UART ALU: parses framed packets from uart_rx,
// runs echo / add / multiply and streams the response bytes to uart_tx.
//
// state   | meaning
// HDR_OP  | wait for opcode byte
// HDR_RSV | reserved header byte, discarded
// HDR_LSB | length low byte
// HDR_MSB | length high byte, dispatch on opcode
// ECHO    | forward payload bytes to the output register
// CALC    | assemble little-endian operands and accumulate
// RESULT  | emit the 4 accumulator bytes, LSB first
// DRAIN   | discard payload of an unknown opcode
module alu_packet_engine #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'h01,
  parameter logic [7:0] OP_MUL  = 8'h10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       err_o
);

  typedef enum logic [2:0] {
    HDR_OP, HDR_RSV, HDR_LSB, HDR_MSB, ECHO, CALC, RESULT, DRAIN
  } state_t;

  state_t      state, state_next;
  logic [7:0]  opcode;
  logic [7:0]  len_lsb;
  logic [15:0] cnt;
  logic [31:0] acc;
  logic [31:0] opnd;
  logic [1:0]  byte_idx;
  logic        first_op;
  logic [2:0]  res_cnt;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        err;

  logic        s_ready;
  logic        s_fire;
  logic        m_fire;
  logic        out_free;
  logic        echo_load;
  logic        res_load;
  logic        last_byte;
  logic        operand_done;
  logic        op_known;
  logic [15:0] hdr_len;
  logic [15:0] pay_len;
  logic [31:0] opnd_next;
  logic [31:0] acc_sum;
  logic [31:0] acc_prod;
  logic [31:0] acc_shift;
  logic [7:0]  res_byte;

  assign s_axis_tready = s_ready && !reset_i;
  assign m_axis_tdata  = out_data;
  assign m_axis_tvalid = out_valid;
  assign err_o         = err;

  assign s_fire    = s_axis_tvalid && s_axis_tready;
  assign m_fire    = out_valid && m_axis_tready;
  assign out_free  = !out_valid || m_axis_tready;
  assign last_byte = (cnt == 16'd1);

  assign hdr_len  = {s_axis_tdata, len_lsb};
  assign pay_len  = (hdr_len > 16'd4) ? (hdr_len - 16'd4) : 16'd0;
  assign op_known = (opcode == OP_ECHO) || (opcode == OP_ADD) || (opcode == OP_MUL);

  // A short final operand stays zero-extended because opnd starts cleared.
  assign opnd_next    = opnd | ({24'd0, s_axis_tdata} << {byte_idx, 3'b000});
  assign operand_done = (byte_idx == 2'd3) || last_byte;
  assign acc_sum      = acc + opnd_next;
  assign acc_prod     = acc * opnd_next;
  assign acc_shift    = acc >> {res_cnt[1:0], 3'b000};
  assign res_byte     = acc_shift[7:0];

  assign echo_load = (state == ECHO) && s_fire;
  assign res_load  = (state == RESULT) && (res_cnt < 3'd4) && out_free;

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    case (state)
      HDR_OP: begin
        s_ready = 1'b1;
        if (s_fire) state_next = HDR_RSV;
      end
      HDR_RSV: begin
        s_ready = 1'b1;
        if (s_fire) state_next = HDR_LSB;
      end
      HDR_LSB: begin
        s_ready = 1'b1;
        if (s_fire) state_next = HDR_MSB;
      end
      HDR_MSB: begin
        s_ready = 1'b1;
        if (s_fire) begin
          if (opcode == OP_ECHO)
            state_next = (pay_len == 16'd0) ? HDR_OP : ECHO;
          else if ((opcode == OP_ADD) || (opcode == OP_MUL))
            state_next = (pay_len == 16'd0) ? RESULT : CALC;
          else
            state_next = (pay_len == 16'd0) ? HDR_OP : DRAIN;
        end
      end
      ECHO: begin
        s_ready = out_free;
        if (s_fire && last_byte) state_next = HDR_OP;
      end
      CALC: begin
        s_ready = 1'b1;
        if (s_fire && last_byte) state_next = RESULT;
      end
      RESULT: begin
        if (m_fire && (res_cnt == 3'd4)) state_next = HDR_OP;
      end
      DRAIN: begin
        s_ready = 1'b1;
        if (s_fire && last_byte) state_next = HDR_OP;
      end
      default: state_next = HDR_OP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= HDR_OP;
      opcode    <= 8'd0;
      len_lsb   <= 8'd0;
      cnt       <= 16'd0;
      acc       <= 32'd0;
      opnd      <= 32'd0;
      byte_idx  <= 2'd0;
      first_op  <= 1'b0;
      res_cnt   <= 3'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      err   <= 1'b0;

      if (echo_load) begin
        out_data  <= s_axis_tdata;
        out_valid <= 1'b1;
      end else if (res_load) begin
        out_data  <= res_byte;
        out_valid <= 1'b1;
      end else if (m_fire) begin
        out_valid <= 1'b0;
      end

      case (state)
        HDR_OP: if (s_fire) opcode <= s_axis_tdata;
        HDR_LSB: if (s_fire) len_lsb <= s_axis_tdata;
        HDR_MSB: begin
          if (s_fire) begin
            cnt      <= pay_len;
            acc      <= 32'd0;
            opnd     <= 32'd0;
            byte_idx <= 2'd0;
            first_op <= 1'b1;
            res_cnt  <= 3'd0;
            err      <= !op_known;
          end
        end
        ECHO, DRAIN: if (s_fire) cnt <= cnt - 16'd1;
        CALC: begin
          if (s_fire) begin
            cnt <= cnt - 16'd1;
            if (operand_done) begin
              opnd     <= 32'd0;
              byte_idx <= 2'd0;
              first_op <= 1'b0;
              if (opcode == OP_ADD)
                acc <= acc_sum;
              else
                acc <= first_op ? opnd_next : acc_prod;
            end else begin
              opnd     <= opnd_next;
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        RESULT: begin
          if (res_load) begin
            res_cnt <= res_cnt + 3'd1;
          end else if (m_fire && (res_cnt == 3'd4)) begin
            acc     <= 32'd0;
            res_cnt <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
